// File: rtl/pwm_peripheral.sv
// PWM output stage: prescaled 8-bit period counter, period-synchronised duty shadow,
// and per-pin low / static-high / PWM selection into 16 registered chip outputs.
module pwm_peripheral #(
  parameter int W       = 8,
  parameter int CLK_DIV = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   en_reg_out_7_0,
  input  logic [W-1:0]   en_reg_out_15_8,
  input  logic [W-1:0]   en_reg_pwm_7_0,
  input  logic [W-1:0]   en_reg_pwm_15_8,
  input  logic [W-1:0]   pwm_duty_cycle,
  output logic [2*W-1:0] out,
  output logic           period_start
);

  localparam int            PS_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(CLK_DIV - 1);
  localparam logic [W-1:0]  CNT_MAX = '1;

  logic [PS_W-1:0] prescaler;
  logic [W-1:0]    pwm_cnt;
  logic [W-1:0]    duty_shadow;
  logic            step;
  logic            wrap;
  logic            pwm_sig;
  logic [2*W-1:0]  en_out;
  logic [2*W-1:0]  en_pwm;
  logic [2*W-1:0]  out_nxt;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};
  assign step   = (prescaler == PS_LAST);
  assign wrap   = step && (pwm_cnt == CNT_MAX);

  // Full-scale duty is special-cased so the pin never dips low at the counter wrap
  always_comb begin
    pwm_sig = 1'b0;
    if (duty_shadow == CNT_MAX) pwm_sig = 1'b1;
    else                        pwm_sig = (pwm_cnt < duty_shadow);
  end

  assign out_nxt = en_out & (~en_pwm | {(2*W){pwm_sig}});

  // Stage boundary: counter state, duty shadow and output pins all register here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescaler    <= '0;
      pwm_cnt      <= '0;
      duty_shadow  <= '0;
      period_start <= 1'b0;
      out          <= '0;
    end else begin
      prescaler    <= step ? '0 : prescaler + 1'b1;
      if (step) pwm_cnt <= pwm_cnt + 1'b1;
      if (wrap) duty_shadow <= pwm_duty_cycle;
      period_start <= wrap;
      out          <= out_nxt;
    end
  end

endmodule
